uart_core_cfg: RTL and testbench

- Runtime-configurable full-duplex UART engine. Successor to the fixed 8N1 UART: adds 5–8 data bits, none/even/odd parity, 1/2 stop bits and a runtime baud divisor with 16x oversampling.
- Adds per-frame parity/framing error flags, a sticky overrun flag, internal loopback and start-bit glitch rejection.
- Sits between the byte-level system side (FIFOs/controller) and the external serial pins.

---
 rtl/uart_cfg_pkg.sv | 52 +++++
 rtl/uart_core_cfg_baud.sv | 29 ++
 rtl/uart_core_cfg.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_core_cfg.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared types and config decode helpers for the configurable UART core.
package uart_cfg_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // 2-bit data-bits code -> 5..8
  function automatic logic [3:0] data_bits(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  // Index of the last data bit (N-1), fits in 3 bits.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] code);
    return {1'b1, code};
  endfunction

  // Mask keeping the N low data bits
  function automatic logic [7:0] data_mask(input logic [1:0] code);
    return 8'hFF >> (2'd3 - code);
  endfunction

  // 2'b11 is treated as no parity
  function automatic parity_e decode_parity(input logic [1:0] code);
    case (code)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_core_cfg_baud.sv
// Restartable prescaler: counts 0..div_i and pulses tick_o on the terminal count.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Next count: wrap at terminal count, or restart from zero with the engine
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == div_i)) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A restart cycle never ticks, so the first bit gets a full (div+1) period
  assign tick_o = (cnt_q == div_i) && !restart_i;

endmodule

// File: rtl/uart_core_cfg.sv
// Runtime-configurable full-duplex UART: 5-8 data bits, none/even/odd parity,
// 1/2 stop bits, oversampled RX with glitch rejection, loopback and error flags.
module uart_core_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [1:0]       i_cfg_data_bits,
  input  logic [1:0]       i_cfg_parity,
  input  logic             i_cfg_stop2,
  input  logic             i_loopback,
  input  logic [7:0]       i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic             o_tx_serial,
  output logic             o_tx_busy,
  input  logic             i_rx_serial,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic             o_rx_parity_err,
  output logic             o_rx_frame_err,
  output logic             o_rx_overrun,
  input  logic             i_err_clr,
  output logic             o_rx_busy
);

  localparam int              OS_W      = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] TCNT_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] TCNT_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  // ---------------------------------------------------------------- TX ----
  tx_state_e        tx_state_q;
  logic [OS_W-1:0]  tx_tcnt_q;
  logic [2:0]       tx_bcnt_q;
  logic [7:0]       tx_shift_q;
  logic [1:0]       tx_bits_q;
  logic             tx_par_en_q;
  logic             tx_par_q;
  logic             tx_stop2_q;
  logic             tx_line_q;
  logic [DIV_W-1:0] tx_div_q;
  logic             tx_tick, tx_accept, tx_bit_end;

  assign o_tx_ready = (tx_state_q == TX_IDLE);
  assign o_tx_busy  = (tx_state_q != TX_IDLE);
  assign tx_accept  = i_tx_valid && o_tx_ready;
  assign tx_bit_end = tx_tick && (tx_tcnt_q == TCNT_LAST);
  // Loopback keeps the pin idle; the frame only travels on the internal line
  assign o_tx_serial = tx_line_q | i_loopback;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tx_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (tx_accept),
    .div_i     (tx_div_q),
    .tick_o    (tx_tick)
  );

  // TX FSM: latch byte and config on accept, then walk the frame one bit per OVERSAMPLE ticks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_tcnt_q   <= '0;
      tx_bcnt_q   <= '0;
      tx_shift_q  <= '0;
      tx_bits_q   <= '0;
      tx_par_en_q <= 1'b0;
      tx_par_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_line_q   <= 1'b1;
      tx_div_q    <= '0;
    end else begin
      if (tx_tick) tx_tcnt_q <= tx_tcnt_q + 1'b1;
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_accept) begin
            tx_state_q  <= TX_START;
            tx_line_q   <= 1'b0;
            tx_tcnt_q   <= '0;
            tx_bcnt_q   <= '0;
            tx_shift_q  <= i_tx_data;
            tx_bits_q   <= i_cfg_data_bits;
            tx_stop2_q  <= i_cfg_stop2;
            tx_div_q    <= i_cfg_div;
            tx_par_en_q <= (decode_parity(i_cfg_parity) != PAR_NONE);
            tx_par_q    <= (^(i_tx_data & data_mask(i_cfg_data_bits)))
                           ^ (decode_parity(i_cfg_parity) == PAR_ODD);
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_DATA;
            tx_line_q  <= tx_shift_q[0];
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bcnt_q == last_bit_idx(tx_bits_q)) begin
              tx_state_q <= tx_par_en_q ? TX_PARITY : TX_STOP1;
              tx_line_q  <= tx_par_en_q ? tx_par_q : 1'b1;
            end else begin
              tx_shift_q <= tx_shift_q >> 1;
              tx_line_q  <= tx_shift_q[1];
              tx_bcnt_q  <= tx_bcnt_q + 1'b1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_STOP1;
            tx_line_q  <= 1'b1;
          end
        end
        TX_STOP1: begin
          if (tx_bit_end) tx_state_q <= tx_stop2_q ? TX_STOP2 : TX_IDLE;
        end
        TX_STOP2: begin
          if (tx_bit_end) tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX ----
  rx_state_e              rx_state_q;
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic                   rx_prev_q;
  logic [OS_W-1:0]        rx_tcnt_q;
  logic [2:0]             rx_bcnt_q;
  logic [7:0]             rx_shift_q;
  logic [1:0]             rx_bits_q;
  logic                   rx_par_en_q;
  logic                   rx_odd_q;
  logic                   rx_acc_q;
  logic [DIV_W-1:0]       rx_div_q;
  logic                   rx_in, rx_fall, rx_restart, rx_tick, rx_bit_end, rx_complete;
  logic [7:0]             rx_frame_data;
  logic                   rx_frame_perr, rx_frame_ferr;
  logic [7:0]             rx_data_q;
  logic                   rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q;

  assign rx_in       = i_loopback ? tx_line_q : rx_sync_q[SYNC_STAGES-1];
  assign rx_fall     = rx_prev_q && !rx_in;
  assign rx_restart  = (rx_state_q == RX_IDLE) && rx_fall;
  assign rx_bit_end  = rx_tick && (rx_tcnt_q == TCNT_LAST);
  assign rx_complete = (rx_state_q == RX_STOP) && rx_bit_end;
  // Bits arrive LSB first into the top of the shifter; realign to bit 0
  assign rx_frame_data = rx_shift_q >> (2'd3 - rx_bits_q);
  // Accumulator holds XOR of data and parity bit: even expects 0, odd expects 1
  assign rx_frame_perr = rx_par_en_q && (rx_acc_q ^ rx_odd_q);
  assign rx_frame_ferr = !rx_in;

  assign o_rx_busy       = (rx_state_q != RX_IDLE);
  assign o_rx_data       = rx_data_q;
  assign o_rx_valid      = rx_valid_q;
  assign o_rx_parity_err = rx_perr_q;
  assign o_rx_frame_err  = rx_ferr_q;
  assign o_rx_overrun    = rx_ovr_q;

  uart_baud_tick #(.DIV_W(DIV_W)) u_rx_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (rx_restart),
    .div_i     (rx_div_q),
    .tick_o    (rx_tick)
  );

  // Metastability synchroniser for the asynchronous serial input (SYNC_STAGES >= 2)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync_q <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], i_rx_serial};
      rx_prev_q <= rx_in;
    end
  end

  // RX FSM: qualify start at half-bit, then sample each later bit one bit-time apart
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      rx_tcnt_q   <= '0;
      rx_bcnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_bits_q   <= '0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
      rx_acc_q    <= 1'b0;
      rx_div_q    <= '0;
    end else begin
      if (rx_tick) rx_tcnt_q <= rx_tcnt_q + 1'b1;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_q  <= RX_START;
            rx_tcnt_q   <= '0;
            rx_bcnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_acc_q    <= 1'b0;
            rx_bits_q   <= i_cfg_data_bits;
            rx_div_q    <= i_cfg_div;
            rx_par_en_q <= (decode_parity(i_cfg_parity) != PAR_NONE);
            rx_odd_q    <= (decode_parity(i_cfg_parity) == PAR_ODD);
          end
        end
        RX_START: begin
          // Re-phase the tick counter so later samples land mid-bit at TCNT_LAST
          if (rx_tick && (rx_tcnt_q == TCNT_MID)) begin
            rx_state_q <= rx_in ? RX_IDLE : RX_DATA;
            rx_tcnt_q  <= '0;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_shift_q <= {rx_in, rx_shift_q[7:1]};
            rx_acc_q   <= rx_acc_q ^ rx_in;
            rx_bcnt_q  <= rx_bcnt_q + 1'b1;
            if (rx_bcnt_q == last_bit_idx(rx_bits_q))
              rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (rx_bit_end) begin
            rx_acc_q   <= rx_acc_q ^ rx_in;
            rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          // A low stop bit may be a break: wait for the line to go high before re-arming
          if (rx_bit_end) rx_state_q <= rx_in ? RX_IDLE : RX_WAIT_HIGH;
        end
        RX_WAIT_HIGH: begin
          if (rx_in) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      if (i_err_clr) rx_ovr_q <= 1'b0;
      if (rx_complete) begin
        if (!rx_valid_q || i_rx_ready) begin
          rx_data_q  <= rx_frame_data;
          rx_perr_q  <= rx_frame_perr;
          rx_ferr_q  <= rx_frame_ferr;
          rx_valid_q <= 1'b1;
        end else begin
          rx_ovr_q <= 1'b1;  // set beats a simultaneous clear
        end
      end else if (i_rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core_cfg.sv
// Self-checking bench for uart_core_cfg: directed table, corner sequences, randomized loop.
module tb_uart_core_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_cfg_div;
  logic [1:0]  i_cfg_data_bits, i_cfg_parity;
  logic        i_cfg_stop2, i_loopback;
  logic [7:0]  i_tx_data;
  logic        i_tx_valid, o_tx_ready, o_tx_serial, o_tx_busy;
  logic        i_rx_serial;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid, i_rx_ready, o_rx_parity_err, o_rx_frame_err, o_rx_overrun;
  logic        i_err_clr, o_rx_busy;

  logic        rx_drv, ext_loop;
  assign i_rx_serial = ext_loop ? o_tx_serial : rx_drv;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_bits[$];

  uart_core_cfg #(.DIV_W(16), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_div(i_cfg_div), .i_cfg_data_bits(i_cfg_data_bits),
    .i_cfg_parity(i_cfg_parity), .i_cfg_stop2(i_cfg_stop2), .i_loopback(i_loopback),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_tx_serial(o_tx_serial), .o_tx_busy(o_tx_busy), .i_rx_serial(i_rx_serial),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
    .o_rx_parity_err(o_rx_parity_err), .o_rx_frame_err(o_rx_frame_err),
    .o_rx_overrun(o_rx_overrun), .i_err_clr(i_err_clr), .o_rx_busy(o_rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: start, N data bits LSB first, optional parity, 1 or 2 stops
  task automatic build_frame(input logic [7:0] d, input int bits, input int par, input bit st2);
    bit p = 1'b0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 5 + bits; i++) begin
      exp_bits.push_back(d[i]);
      p ^= d[i];
    end
    if (par == 1) exp_bits.push_back(p);
    if (par == 2) exp_bits.push_back(!p);
    exp_bits.push_back(1'b1);
    if (st2) exp_bits.push_back(1'b1);
  endtask

  function automatic logic [7:0] mask_of(input int bits);
    return 8'((1 << (5 + bits)) - 1);
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int g = 0;
    while (!o_tx_ready && g < 20000) begin tick(1); g++; end
    check("tx_ready_before_send", o_tx_ready, 1'b1);
    i_tx_data  = d;
    i_tx_valid = 1'b1;
    tick(1);
    i_tx_valid = 1'b0;
  endtask

  // Walks one TX frame from the accept edge; checks pin mid-bit, ready timing, RX arrival
  task automatic tx_frame_check(input bit chk_pin, input bit pin_idle, input int div,
                                output int valid_at);
    int bit_c = 16 * (div + 1);
    int len   = exp_bits.size() * bit_c;
    bit ready_bad = 1'b0, pin_bad = 1'b0;
    valid_at = -1;
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      if (chk_pin && (c < len) && (c % bit_c == bit_c / 2))
        check("tx_pin_bit", o_tx_serial, exp_bits[c / bit_c]);
      if (pin_idle && o_tx_serial !== 1'b1) pin_bad = 1'b1;
      if (c < len && o_tx_ready !== 1'b0) ready_bad = 1'b1;
      if (o_rx_valid === 1'b1 && valid_at < 0) valid_at = c;
      if (c == len) check("tx_ready_after_frame", o_tx_ready, 1'b1);
      @(posedge clk); #1;
    end
    check("tx_ready_low_in_frame", ready_bad, 1'b0);
    if (pin_idle) check("tx_pin_idle_loopback", pin_bad, 1'b0);
  endtask

  // Drives an RX frame on the external line; leaves the line at the stop value
  task automatic drive_frame(input logic [7:0] d, input int bits, input int par,
                             input bit flip, input bit stop_val, input int bit_c);
    bit p = 1'b0;
    rx_drv = 1'b0; tick(bit_c);
    for (int i = 0; i < 5 + bits; i++) begin
      rx_drv = d[i]; p ^= d[i]; tick(bit_c);
    end
    if (par == 1 || par == 2) begin
      rx_drv = p ^ (par == 2) ^ flip; tick(bit_c);
    end
    rx_drv = stop_val; tick(bit_c);
  endtask

  task automatic pulse_ready();
    i_rx_ready = 1'b1; tick(1); i_rx_ready = 1'b0;
    check("rx_valid_drop_after_ready", o_rx_valid, 1'b0);
  endtask

  typedef struct {
    logic [1:0] bits;
    logic [1:0] par;
    logic [7:0] data;
    bit         flip;
    bit         stop_val;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } rx_vec_t;

  rx_vec_t tbl[5];

  initial begin
    int va;
    tbl[0] = '{2'd3, 2'd2, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};  // 8O1 bad parity
    tbl[1] = '{2'd3, 2'd1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};  // 8E1 good
    tbl[2] = '{2'd0, 2'd0, 8'hFF, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};  // 5N1
    tbl[3] = '{2'd1, 2'd2, 8'h2A, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1};  // 6O1 stop low
    tbl[4] = '{2'd2, 2'd3, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};  // 7N1 (code 11)

    rst_n = 1'b0; i_cfg_div = 16'd26; i_cfg_data_bits = 2'd3; i_cfg_parity = 2'd0;
    i_cfg_stop2 = 1'b0; i_loopback = 1'b0; i_tx_data = 8'h00; i_tx_valid = 1'b0;
    i_rx_ready = 1'b0; i_err_clr = 1'b0; rx_drv = 1'b1; ext_loop = 1'b0;
    tick(5);
    check("rst_tx_serial", o_tx_serial, 1'b1);
    check("rst_tx_ready", o_tx_ready, 1'b1);
    check("rst_tx_busy", o_tx_busy, 1'b0);
    check("rst_rx_valid", o_rx_valid, 1'b0);
    check("rst_rx_data", o_rx_data, 8'h00);
    check("rst_errs", {o_rx_parity_err, o_rx_frame_err, o_rx_overrun}, 3'b000);
    check("rst_rx_busy", o_rx_busy, 1'b0);
    rst_n = 1'b1; tick(5);

    // Loopback 8N1 0x55
    i_loopback = 1'b1;
    build_frame(8'h55, 3, 0, 1'b0);
    send_byte(8'h55);
    tx_frame_check(1'b0, 1'b1, 26, va);
    check("lb_rx_latency_window", (va >= 4000 && va <= 4400), 1'b1);
    check("lb_rx_data", o_rx_data, 8'h55);
    check("lb_rx_errs", {o_rx_parity_err, o_rx_frame_err, o_rx_overrun}, 3'b000);
    pulse_ready();
    i_loopback = 1'b0;

    // External 7E2 0x41 on the pin
    i_cfg_data_bits = 2'd2; i_cfg_parity = 2'd1; i_cfg_stop2 = 1'b1;
    build_frame(8'h41, 2, 1, 1'b1);
    send_byte(8'h41);
    tx_frame_check(1'b1, 1'b0, 26, va);
    check("7e2_no_rx_activity", o_rx_valid, 1'b0);
    i_cfg_stop2 = 1'b0;

    // Directed RX table
    foreach (tbl[k]) begin
      i_cfg_data_bits = tbl[k].bits; i_cfg_parity = tbl[k].par;
      drive_frame(tbl[k].data, int'(tbl[k].bits), int'(tbl[k].par), tbl[k].flip,
                  tbl[k].stop_val, 432);
      rx_drv = 1'b1; tick(432);
      check("tbl_rx_valid", o_rx_valid, 1'b1);
      check("tbl_rx_data", o_rx_data, tbl[k].exp_data);
      check("tbl_rx_perr", o_rx_parity_err, tbl[k].exp_perr);
      check("tbl_rx_ferr", o_rx_frame_err, tbl[k].exp_ferr);
      pulse_ready();
    end

    // Stop low then line held low: delivered with frame error, no re-arm while low
    i_cfg_data_bits = 2'd3; i_cfg_parity = 2'd0;
    drive_frame(8'h81, 3, 0, 1'b0, 1'b0, 432);
    check("brk_rx_data", o_rx_data, 8'h81);
    check("brk_ferr", o_rx_frame_err, 1'b1);
    pulse_ready();
    tick(3 * 432);
    check("brk_no_rearm_low", o_rx_valid, 1'b0);
    rx_drv = 1'b1; tick(432);
    drive_frame(8'h5A, 3, 0, 1'b0, 1'b1, 432);
    rx_drv = 1'b1; tick(432);
    check("brk_next_data", o_rx_data, 8'h5A);
    check("brk_next_ferr", o_rx_frame_err, 1'b0);
    pulse_ready();

    // Overrun: second frame dropped while first unread
    drive_frame(8'hA0, 3, 0, 1'b0, 1'b1, 432); tick(432);
    drive_frame(8'hA1, 3, 0, 1'b0, 1'b1, 432); tick(432);
    check("ovr_data_kept", o_rx_data, 8'hA0);
    check("ovr_flag", o_rx_overrun, 1'b1);
    i_err_clr = 1'b1; tick(1); i_err_clr = 1'b0;
    check("ovr_cleared", o_rx_overrun, 1'b0);
    check("ovr_valid_kept", o_rx_valid, 1'b1);
    pulse_ready();
    i_rx_ready = 1'b1;
    drive_frame(8'h00, 3, 0, 1'b0, 1'b1, 432); tick(432);
    drive_frame(8'h01, 3, 0, 1'b0, 1'b1, 432); tick(432);
    check("pair_no_ovr", o_rx_overrun, 1'b0);
    check("pair_last_data", o_rx_data, 8'h01);
    i_rx_ready = 1'b0;

    // Start glitch of 3 ticks is rejected
    rx_drv = 1'b0; tick(3 * 27); rx_drv = 1'b1; tick(2 * 432);
    check("glitch_no_valid", o_rx_valid, 1'b0);
    check("glitch_rx_idle", o_rx_busy, 1'b0);

    // Randomized frames against the frame model, pin looped or internal loopback
    for (int k = 0; k < 16; k++) begin
      int bits = $urandom_range(0, 3);
      int par  = $urandom_range(0, 3);
      int div  = $urandom_range(0, 3);
      bit st2  = 1'($urandom_range(0, 1));
      bit lb   = 1'($urandom_range(0, 1));
      logic [7:0] d = 8'($urandom_range(0, 255));
      i_cfg_div = 16'(div); i_cfg_data_bits = 2'(bits); i_cfg_parity = 2'(par);
      i_cfg_stop2 = st2; i_loopback = lb; ext_loop = !lb;
      build_frame(d, bits, (par == 3) ? 0 : par, st2);
      send_byte(d);
      tx_frame_check(!lb, lb, div, va);
      check("rnd_rx_arrived", (va >= 0), 1'b1);
      check("rnd_rx_data", o_rx_data, d & mask_of(bits));
      check("rnd_rx_errs", {o_rx_parity_err, o_rx_frame_err, o_rx_overrun}, 3'b000);
      pulse_ready();
    end
    ext_loop = 1'b0; i_loopback = 1'b0; i_cfg_div = 16'd26; i_cfg_stop2 = 1'b0;
    i_cfg_data_bits = 2'd3; i_cfg_parity = 2'd0;

    // Reset mid-TX returns the line high and ready immediately
    send_byte(8'h00);
    tick(1000);
    check("rstmid_line_low_before", o_tx_serial, 1'b0);
    rst_n = 1'b0; tick(1);
    check("rstmid_tx_serial", o_tx_serial, 1'b1);
    check("rstmid_tx_ready", o_tx_ready, 1'b1);
    check("rstmid_tx_busy", o_tx_busy, 1'b0);
    rst_n = 1'b1; tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
